// File: rtl/fda_pkg.sv
// rtl/fda_pkg.sv - shared types and constants for the ADC frame packetizer
package fda_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAY_REQ,
        ST_PAY_WAIT,
        ST_PAY_TX,
        ST_CHK,
        ST_DONE
    } fda_state_t;

    localparam logic [7:0] FDA_SYNC0    = 8'hA5;
    localparam logic [7:0] FDA_SYNC1    = 8'h5A;
    localparam logic [7:0] FDA_PAD_BYTE = 8'h00;

    typedef logic [15:0] fda_len_t;

    // Byte that brings the 8-bit sum of length, payload and itself to zero.
    function automatic logic [7:0] fda_check_byte(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// rtl/tx_byte_handshake.sv - request/accept front end for the UART write port
module tx_byte_handshake (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] req_data,
    input  logic       tx_busy,
    output logic       accept,
    output logic [7:0] tx_data,
    output logic       tx_wr
);

    logic holdoff;

    // The UART raises busy a cycle late, so block both the strobe cycle and the one after it.
    assign accept = req && !tx_busy && !tx_wr && !holdoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr   <= 1'b0;
            tx_data <= 8'h00;
            holdoff <= 1'b0;
        end else begin
            tx_wr   <= accept;
            holdoff <= tx_wr;
            if (accept) begin
                tx_data <= req_data;
            end
        end
    end

endmodule

// File: rtl/adc_frame_packetizer.sv
// rtl/adc_frame_packetizer.sv - frames capture FIFO bytes as sync/length/payload/check packets
module adc_frame_packetizer
    import fda_pkg::*;
#(
    parameter logic [7:0]  SYNC0          = FDA_SYNC0,
    parameter logic [7:0]  SYNC1          = FDA_SYNC1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  PAD_BYTE       = FDA_PAD_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] frame_len,
    input  logic        data_ready,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        frame_active,
    output logic [7:0]  frame_count,
    output logic        underrun
);

    fda_state_t  state;
    fda_len_t    len_q;
    fda_len_t    remaining;
    logic [7:0]  checksum;
    logic [31:0] timeout_cnt;
    logic [7:0]  hold_q;
    logic        pad_mode;

    logic        req;
    logic [7:0]  req_data;
    logic        accept;

    always_comb begin
        req      = 1'b0;
        req_data = hold_q;
        case (state)
            ST_SYNC0:  begin req = 1'b1; req_data = SYNC0;        end
            ST_SYNC1:  begin req = 1'b1; req_data = SYNC1;        end
            ST_LEN_HI: begin req = 1'b1; req_data = len_q[15:8];  end
            ST_LEN_LO: begin req = 1'b1; req_data = len_q[7:0];   end
            ST_PAY_TX: begin req = 1'b1; req_data = hold_q;       end
            ST_CHK:    begin req = 1'b1; req_data = fda_check_byte(checksum); end
            default:   ;
        endcase
    end

    tx_byte_handshake u_tx_hs (
        .clk      (clk),
        .rst_n    (reset_n),
        .req      (req),
        .req_data (req_data),
        .tx_busy  (tx_busy),
        .accept   (accept),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            remaining    <= '0;
            checksum     <= 8'h00;
            timeout_cnt  <= 32'd0;
            hold_q       <= 8'h00;
            pad_mode     <= 1'b0;
            fifo_rd      <= 1'b0;
            frame_active <= 1'b0;
            frame_count  <= 8'h00;
            underrun     <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && data_ready) begin
                        len_q        <= frame_len;
                        remaining    <= frame_len;
                        checksum     <= 8'h00;
                        timeout_cnt  <= 32'd0;
                        frame_active <= 1'b1;
                        state        <= ST_SYNC0;
                    end
                end
                ST_SYNC0: if (accept) state <= ST_SYNC1;
                ST_SYNC1: if (accept) state <= ST_LEN_HI;
                ST_LEN_HI: begin
                    if (accept) begin
                        checksum <= checksum + len_q[15:8];
                        state    <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        checksum <= checksum + len_q[7:0];
                        state    <= (len_q == 16'd0) ? ST_CHK : ST_PAY_REQ;
                    end
                end
                ST_PAY_REQ: begin
                    if (data_ready) begin
                        fifo_rd     <= 1'b1;
                        timeout_cnt <= 32'd0;
                        state       <= ST_PAY_WAIT;
                    end else if (timeout_cnt == TIMEOUT_CYCLES - 1) begin
                        pad_mode    <= 1'b1;
                        underrun    <= 1'b1;
                        hold_q      <= PAD_BYTE;
                        timeout_cnt <= 32'd0;
                        state       <= ST_PAY_TX;
                    end else begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                ST_PAY_WAIT: begin
                    // The FIFO registers the strobe, so its data lands the cycle after fifo_rd drops.
                    if (!fifo_rd) begin
                        hold_q <= fifo_data;
                        state  <= ST_PAY_TX;
                    end
                end
                ST_PAY_TX: begin
                    if (accept) begin
                        checksum  <= checksum + hold_q;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_CHK;
                        end else if (!pad_mode) begin
                            state <= ST_PAY_REQ;
                        end
                    end
                end
                ST_CHK: if (accept) state <= ST_DONE;
                ST_DONE: begin
                    frame_count  <= frame_count + 8'd1;
                    frame_active <= 1'b0;
                    pad_mode     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
